// File: rtl/descramble_sync.sv
// rtl/descramble_sync.sv - 100BASE-TX receive descrambler with idle-based lock acquisition
// Optional relock counter port enabled by DESCRAMBLE_SYNC_STATS_EN.
`timescale 1ns/1ps
module descramble_sync #(
  parameter int LOCK_IDLES   = 29,
  parameter int HOLD_IDLES   = 60,
  parameter int IDLE_TIMEOUT = 125000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scrambled,
  input  logic       valid,
  output logic       unscrambled,
  output logic       out_valid,
  output logic       locked,
  output logic       lock_lost
`ifdef DESCRAMBLE_SYNC_STATS_EN
  ,
  output logic [7:0] relocks
`endif
);

  localparam int AW = $clog2(11) + 1;
  localparam int RW = $clog2((HOLD_IDLES > LOCK_IDLES) ? HOLD_IDLES : LOCK_IDLES) + 1;
  localparam int TW = $clog2(IDLE_TIMEOUT) + 1;
  localparam logic [AW-1:0] ACQ_LAST   = AW'(10);
  localparam logic [RW-1:0] LOCK_LAST  = RW'(LOCK_IDLES - 1);
  localparam logic [RW-1:0] HOLD_LAST  = RW'(HOLD_IDLES - 1);
  localparam logic [TW-1:0] TIMER_LAST = TW'(IDLE_TIMEOUT - 1);

  typedef enum logic [1:0] {
    ACQUIRE = 2'd0,
    VERIFY  = 2'd1,
    LOCKED  = 2'd2
  } state_t;

  state_t        state, next_state;
  logic [10:0]   lfsr, lfsr_next;
  logic [AW-1:0] acq_cnt, acq_next;
  logic [RW-1:0] run_cnt, run_next;
  logic [TW-1:0] timer, timer_next;
  logic          fb, d, emit, lose;

  assign fb = lfsr[8] ^ lfsr[10];
  assign d  = scrambled ^ fb;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ACQUIRE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    lfsr_next  = lfsr;
    acq_next   = acq_cnt;
    run_next   = run_cnt;
    timer_next = timer;
    emit       = 1'b0;
    lose       = 1'b0;
    if (valid) begin
      case (state)
        ACQUIRE: begin
          // Line assumed idle: the transmit feedback bit is the inverted received bit.
          lfsr_next = {lfsr[9:0], ~scrambled};
          if (acq_cnt == ACQ_LAST) begin
            next_state = VERIFY;
            acq_next   = '0;
            run_next   = '0;
          end else begin
            acq_next = acq_cnt + 1'b1;
          end
        end
        VERIFY: begin
          lfsr_next = {lfsr[9:0], fb};
          if (!d) begin
            next_state = ACQUIRE;
            acq_next   = '0;
          end else if (run_cnt == LOCK_LAST) begin
            next_state = LOCKED;
            run_next   = '0;
            timer_next = '0;
          end else begin
            run_next = run_cnt + 1'b1;
          end
        end
        LOCKED: begin
          lfsr_next = {lfsr[9:0], fb};
          emit      = 1'b1;
          // A completed idle run beats a coincident timeout.
          if (d && run_cnt == HOLD_LAST) begin
            run_next   = '0;
            timer_next = '0;
          end else begin
            run_next = d ? run_cnt + 1'b1 : '0;
            if (timer == TIMER_LAST) begin
              next_state = ACQUIRE;
              acq_next   = '0;
              run_next   = '0;
              timer_next = '0;
              lose       = 1'b1;
            end else begin
              timer_next = timer + 1'b1;
            end
          end
        end
        default: begin
          next_state = ACQUIRE;
          acq_next   = '0;
          run_next   = '0;
          timer_next = '0;
        end
      endcase
    end
  end

  always_comb begin
    locked = (state == LOCKED);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr    <= '0;
      acq_cnt <= '0;
      run_cnt <= '0;
      timer   <= '0;
    end else begin
      lfsr    <= lfsr_next;
      acq_cnt <= acq_next;
      run_cnt <= run_next;
      timer   <= timer_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      unscrambled <= 1'b0;
      out_valid   <= 1'b0;
      lock_lost   <= 1'b0;
    end else begin
      out_valid <= emit;
      lock_lost <= lose;
      if (emit) unscrambled <= d;
    end
  end

`ifdef DESCRAMBLE_SYNC_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                          relocks <= 8'd0;
    else if (lose && relocks != 8'hff) relocks <= relocks + 8'd1;
  end
`endif

endmodule

// File: tb/tb_descramble_sync.sv
// tb/tb_descramble_sync.sv - scoreboard bench for descramble_sync
// Exercises relocks as well when DESCRAMBLE_SYNC_STATS_EN is defined.
`timescale 1ns/1ps
module tb_descramble_sync;
  localparam int LOCK_IDLES   = 29;
  localparam int HOLD_IDLES   = 60;
  localparam int IDLE_TIMEOUT = 1000;

  logic clk = 1'b0;
  logic rst, scrambled, valid;
  logic unscrambled, out_valid, locked, lock_lost;
`ifdef DESCRAMBLE_SYNC_STATS_EN
  logic [7:0] relocks;
`endif

  int checks   = 0;
  int failures = 0;
  logic exp_q[$];
  logic [10:0] tx;

  descramble_sync #(
    .LOCK_IDLES(LOCK_IDLES),
    .HOLD_IDLES(HOLD_IDLES),
    .IDLE_TIMEOUT(IDLE_TIMEOUT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .scrambled(scrambled),
    .valid(valid),
    .unscrambled(unscrambled),
    .out_valid(out_valid),
    .locked(locked),
    .lock_lost(lock_lost)
`ifdef DESCRAMBLE_SYNC_STATS_EN
    ,
    .relocks(relocks)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Transmit scrambler model; emitted bits are expected back in order.
  task automatic send(input logic data, input logic emit);
    logic f;
    f = tx[8] ^ tx[10];
    scrambled = data ^ f;
    valid = 1'b1;
    tx = {tx[9:0], f};
    if (emit) exp_q.push_back(data);
    @(posedge clk);
    #1;
  endtask

  task automatic gap();
    valid = 1'b0;
    scrambled = 1'b0;
    @(posedge clk);
    #1;
    check("gap_out_valid", 32'(out_valid), 0);
  endtask

  task automatic alt(input int n);
    for (int k = 0; k < n; k++) send(~k[0], 1'b1);
  endtask

  task automatic ones(input int n);
    repeat (n) send(1'b1, 1'b1);
  endtask

  task automatic drain(input string tag);
    @(negedge clk);
    #1;
    check(tag, 32'(exp_q.size()), 0);
    exp_q.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    valid = 1'b0;
    scrambled = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
  endtask

  task automatic acquire(input logic [10:0] seed, input string tag);
    tx = seed;
    repeat (10 + LOCK_IDLES) send(1'b1, 1'b0);
    check({tag, "_pre"}, 32'(locked), 0);
    send(1'b1, 1'b0);
    check({tag, "_lock"}, 32'(locked), 1);
  endtask

  task automatic flip_acquire(input logic [10:0] seed, input int flip_idx, input string tag);
    tx = seed;
    repeat (flip_idx) send(1'b1, 1'b0);
    send(1'b0, 1'b0);
    check({tag, "_after_flip"}, 32'(locked), 0);
    repeat (39) send(1'b1, 1'b0);
    check({tag, "_pre"}, 32'(locked), 0);
    send(1'b1, 1'b0);
    check({tag, "_lock"}, 32'(locked), 1);
  endtask

  always @(negedge clk) begin
    if (!rst && out_valid) begin
      if (exp_q.size() == 0) check("spurious_out_valid", 32'(out_valid), 0);
      else check("data", 32'(unscrambled), 32'(exp_q.pop_front()));
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    valid = 1'b0;
    scrambled = 1'b0;
    #1;
    check("rst_locked", 32'(locked), 0);
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_unscrambled", 32'(unscrambled), 0);
    check("rst_lock_lost", 32'(lock_lost), 0);
`ifdef DESCRAMBLE_SYNC_STATS_EN
    check("rst_relocks", 32'(relocks), 0);
`endif
    @(negedge clk);
    rst = 1'b0;

    // Clean idle acquisition, then idle data out.
    acquire(11'h3ff, "clean");
    ones(20);
    check("idle_unscrambled", 32'(unscrambled), 1);
    drain("clean_drain");

    do_reset();
    flip_acquire(11'h3ff, 20, "flip3ff");
    alt(10);
    drain("flip3ff_drain");

    do_reset();
    flip_acquire(11'h123, 20, "flip123");
    ones(5);
    drain("flip123_drain");

    // Timeout with alternating data.
    do_reset();
    acquire(11'h3ff, "to");
    for (int k = 1; k < IDLE_TIMEOUT; k++) send(k[0], 1'b1);
    check("to_pre_locked", 32'(locked), 1);
    check("to_pre_lock_lost", 32'(lock_lost), 0);
    send(1'b0, 1'b1);
    check("to_locked", 32'(locked), 0);
    check("to_lock_lost", 32'(lock_lost), 1);
    check("to_last_out_valid", 32'(out_valid), 1);
    send(1'b1, 1'b0);
    check("to_pulse_end", 32'(lock_lost), 0);
    check("to_out_valid_off", 32'(out_valid), 0);
`ifdef DESCRAMBLE_SYNC_STATS_EN
    check("to_relocks", 32'(relocks), 1);
`endif
    drain("to_drain");

    // Hold bursts, the first completing exactly at the timeout bit.
    do_reset();
    acquire(11'h123, "hold");
    alt(IDLE_TIMEOUT - HOLD_IDLES);
    ones(HOLD_IDLES);
    check("hold_at_limit_locked", 32'(locked), 1);
    check("hold_at_limit_lost", 32'(lock_lost), 0);
    for (int r = 0; r < 3; r++) begin
      alt(800);
      ones(HOLD_IDLES);
      check("hold_burst_locked", 32'(locked), 1);
    end
    alt(IDLE_TIMEOUT - 1);
    check("hold_restart_locked", 32'(locked), 1);
    alt(1);
    check("hold_restart_timeout", 32'(lock_lost), 1);
`ifdef DESCRAMBLE_SYNC_STATS_EN
    check("hold_relocks", 32'(relocks), 1);
`endif
    drain("hold_drain");

    // Valid on one cycle in three.
    do_reset();
    tx = 11'h5a5;
    repeat (39) begin
      send(1'b1, 1'b0);
      gap();
      gap();
    end
    check("sparse_pre", 32'(locked), 0);
    send(1'b1, 1'b0);
    check("sparse_lock", 32'(locked), 1);
    repeat (5) begin
      gap();
      gap();
      send(1'b1, 1'b1);
    end
    drain("sparse_drain");

    // Asynchronous reset between edges while locked.
    do_reset();
    acquire(11'h2a5, "ar");
    ones(3);
    check("ar_pre_out_valid", 32'(out_valid), 1);
    #2;
    rst = 1'b1;
    #1;
    check("ar_locked", 32'(locked), 0);
    check("ar_out_valid", 32'(out_valid), 0);
    check("ar_unscrambled", 32'(unscrambled), 0);
    exp_q.delete();
    valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    acquire(11'h2a5, "ar_re");
    ones(4);
    drain("ar_drain");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/descramble_sync.md
Name: descramble_sync

Overview:
- Receive-side counterpart of the 100BASE-TX transmit scrambler (LFSR x^11 + x^9 + 1, feedback lfsr[8]^lfsr[10]).
- Acquires descrambler LFSR state from the received idle stream, verifies it, then descrambles continuously.
- Supervises lock with an idle-hold timer and drops back to acquisition on timeout.
- Sits between the NRZI/MLT-3 decoder and the 4B/5B alignment/decode stage, one bit per valid strobe.

Parameters:
- LOCK_IDLES, 29: consecutive descrambled ones in VERIFY required to declare lock.
- HOLD_IDLES, 60: consecutive descrambled ones in LOCKED that restart the hold timer.
- IDLE_TIMEOUT, 125000: valid bits in LOCKED without a HOLD_IDLES run before lock is lost (1 ms at 125 Mbaud).

Ports:
- clk  in  1  bit clock
- rst  in  1  asynchronous reset, active-high
- scrambled  in  1  received scrambled bit
- valid  in  1  scrambled is a new bit this cycle
- unscrambled  out  1  descrambled bit, registered
- out_valid  out  1  unscrambled is valid; only asserted while locked
- locked  out  1  state is LOCKED
- lock_lost  out  1  one-cycle pulse on LOCKED->ACQUIRE

Behaviour:
- Reset (async, rst=1): state=ACQUIRE; lfsr=0; all counters 0; unscrambled=0, out_valid=0, locked=0, lock_lost=0. Asserting rst mid-operation forces these values immediately, regardless of clk.
- All state, counter and LFSR updates occur only on clk edges with valid=1. With valid=0, everything holds except out_valid and lock_lost, which are forced to 0.
- Descrambled bit d = scrambled ^ (lfsr[8]^lfsr[10]).
- ACQUIRE:
  - Assumes the line carries idle, so the unscrambled bit is 1.
  - lfsr <= {lfsr[9:0], ~scrambled}; acq_cnt increments.
  - On the 11th valid bit: go to VERIFY; acq_cnt=0; run_cnt=0.
- VERIFY:
  - lfsr <= {lfsr[9:0], lfsr[8]^lfsr[10]} (free-running).
  - If d=1: run_cnt++. When run_cnt reaches LOCK_IDLES, go to LOCKED with timer=0 and run_cnt=0.
  - If d=0: go to ACQUIRE with acq_cnt=0. That bit is not reused.
- LOCKED:
  - LFSR free-runs; locked=1.
  - Each valid bit: unscrambled<=d, out_valid<=1 on the next cycle. Latency is 1 clk from valid.
  - Each valid bit: run_cnt++ if d=1, else run_cnt=0. timer++.
  - If run_cnt reaches HOLD_IDLES: timer=0, run_cnt=0 (run restarts).
  - If timer reaches IDLE_TIMEOUT-1 without a hold event on the same bit: go to ACQUIRE, lock_lost pulses 1 cycle, locked=0.
  - Hold event and timeout on the same bit: the hold wins and lock is retained.
  - The transition bit itself is still emitted with out_valid=1.
- In ACQUIRE/VERIFY: out_valid=0 and unscrambled holds its last value.
- Counter widths: $clog2 of the respective parameter + 1. Counters never wrap because every terminal value causes a reset or transition.
- State encoding is free. An unreachable encoding must recover to ACQUIRE on the next valid bit.

Optional Feature:
- Macro: DESCRAMBLE_SYNC_STATS_EN.
- Defined: adds output port relocks [7:0].
  - Saturating count of LOCKED->ACQUIRE transitions; holds at 255.
  - Reset to 0 by rst.
  - Updates in the same cycle lock_lost is asserted.
- Undefined: port and counter are absent; all other behaviour is identical.

Test Plan:
- Idle stream from the scrambler model, seed 11'h3ff, valid=1 continuous: locked rises after exactly 40 valid bits (11+29); out_valid=1 and unscrambled=1 from the next cycle.
- Same stream with bit 20 flipped (inside VERIFY): returns to ACQUIRE; locked rises 40 bits after the flipped bit. Also with seed 11'h123 to prove seed independence.
- Locked, then data pattern 1010... scrambled (no run of 60 ones) for 125000 bits: lock_lost pulses once, locked=0, out_valid=0 afterwards; relocks=1 with DESCRAMBLE_SYNC_STATS_EN.
- Locked, 60-one idle burst every 100000 bits of 1010 data: locked stays 1 for 500000 bits. Include a burst whose 60th one lands on timer=IDLE_TIMEOUT-1: lock retained.
- valid toggled 1-of-3 cycles during acquisition: lock after 40 valid bits (about 120 clks); no out_valid on valid=0 cycles.
- rst pulsed asynchronously between clk edges while locked: locked, out_valid, unscrambled go to 0 before the next edge; full 40-bit reacquisition after release.
